// File: rtl/uart_rx_buffer.sv
// Purpose : show-ahead FIFO holding received UART frames {parity_err, data} plus sticky overrun/interrupt flags.
// Latency : one clock from wr_en to head/count/interrupt; one clock from rd_en to the next head.
// Backpres: none upstream; a frame written while full with no pop drops the frame and sets overrun.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wr_en, wr_data, wr_parity_err   frame-complete strobe from the receiver, with its data and parity flag
//   rd_en                           pop strobe from the register interface
//   clear_interrupt, clear_overrun  one-cycle strobes that clear the sticky flags
//   rd_data, rd_parity_err          head entry (zero when empty)
//   empty, full, count              occupancy, decoded from the registered count
//   overrun, interrupt              sticky status flags
module uart_rx_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       wr_parity_err,
  input  logic                       rd_en,
  input  logic                       clear_interrupt,
  input  logic                       clear_overrun,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_parity_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  output logic                       interrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Entry layout: bit DW is the parity error flag, bits DW-1:0 the data.
  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;
  logic drop;

  // A pop of a full FIFO frees the slot the simultaneous write lands in,
  // so a write is accepted when full as long as a valid pop accompanies it.
  assign rd_ok = rd_en && (count != '0);
  assign wr_ok = wr_en && ((count != DEPTH_C) || rd_ok);
  assign drop  = wr_en && !wr_ok;

  // Storage is deliberately left out of reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {wr_parity_err, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // Set has priority over clear so a frame arriving in the clear cycle is not lost.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      if (wr_en) begin
        interrupt <= 1'b1;
      end else if (clear_interrupt) begin
        interrupt <= 1'b0;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Show-ahead head; masked to zero so stale (or never-written) memory never leaks out.
  always_comb begin
    rd_data       = '0;
    rd_parity_err = 1'b0;
    if (!empty) begin
      rd_data       = mem[rd_ptr][DW-1:0];
      rd_parity_err = mem[rd_ptr][DW];
    end
  end

endmodule
